// File: rtl/paddsb_accum_ctrl_if.sv
// Operand, control and result signals of the PADDSB accumulate sequencer.
// master drives commands and operands; slave is the sequencer itself.
interface paddsb_accum_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [15:0]      init_val;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      result;
  logic [3:0]       ovf;
  logic             busy;

  modport master (
    output start, len, init_val, abort, in_valid, in_data, out_ready,
    input  in_ready, out_valid, result, ovf, busy
  );

  modport slave (
    input  start, len, init_val, abort, in_valid, in_data, out_ready,
    output in_ready, out_valid, result, ovf, busy
  );
endinterface

// File: rtl/paddsb_accum_ctrl.sv
// Accumulates a stream of packed 4x4-bit signed operands with per-lane
// saturation and sticky per-lane overflow, using start/busy and valid/ready.
module paddsb_accum_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  paddsb_accum_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_acc;
  logic [15:0]      w_acc_nxt;
  logic [3:0]       r_sticky;
  logic [3:0]       w_sticky_nxt;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_count_nxt;
  logic [15:0]      r_result;
  logic [3:0]       r_ovf;
  logic [15:0]      w_sum;
  logic [3:0]       w_lane_ovf;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_load_out;

  // Per-lane saturating add, lanes fully independent (no inter-lane carry).
  always_comb begin
    w_sum      = '0;
    w_lane_ovf = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] raw;
      logic       ov;
      a   = r_acc[4*i +: 4];
      b   = bus.in_data[4*i +: 4];
      raw = a + b;
      ov  = (a[3] == b[3]) && (raw[3] != a[3]);
      w_lane_ovf[i]   = ov;
      w_sum[4*i +: 4] = ov ? (a[3] ? 4'b1000 : 4'b0111) : raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_sticky_nxt = r_sticky;
    w_count_nxt  = r_count;
    w_in_ready   = 1'b0;
    w_out_valid  = (r_state == S_DONE);
    if (bus.abort) begin
      w_state_nxt  = S_IDLE;
      w_sticky_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_acc_nxt    = bus.init_val;
            w_sticky_nxt = '0;
            w_count_nxt  = bus.len;
            w_state_nxt  = (bus.len != '0) ? S_ACCUM : S_DONE;
          end
        end
        S_ACCUM: begin
          w_in_ready = 1'b1;
          if (bus.in_valid) begin
            w_acc_nxt    = w_sum;
            w_sticky_nxt = r_sticky | w_lane_ovf;
            w_count_nxt  = r_count - 1'b1;
            if (r_count == LEN_W'(1)) begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Result registers are loaded on the transition into DONE so the final
  // sum is already visible in the first DONE cycle.
  assign w_load_out = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_sticky <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_ovf    <= '0;
    end else begin
      r_acc    <= w_acc_nxt;
      r_sticky <= w_sticky_nxt;
      r_count  <= w_count_nxt;
      if (w_load_out) begin
        r_result <= w_acc_nxt;
        r_ovf    <= w_sticky_nxt;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = r_result;
  assign bus.ovf       = r_ovf;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_paddsb_accum_ctrl.sv
// Directed and randomized checks of paddsb_accum_ctrl against a lane-wise
// integer saturation model.
module tb_paddsb_accum_ctrl;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  paddsb_accum_ctrl_if #(.LEN_W(LEN_W)) bus ();
  paddsb_accum_ctrl #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vecs = 0;
  int errs = 0;
  logic [15:0] opq[$];
  logic [15:0] m_acc;
  logic [3:0]  m_ovf;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {lane overflow flags, saturated packed sum}.
  function automatic logic [19:0] model_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic [3:0]  o;
    logic [3:0]  la;
    logic [3:0]  lb;
    int          x;
    s = '0;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      la = a[4*i +: 4];
      lb = b[4*i +: 4];
      x  = int'($signed(la)) + int'($signed(lb));
      if (x > 7) begin
        x    = 7;
        o[i] = 1'b1;
      end else if (x < -8) begin
        x    = -8;
        o[i] = 1'b1;
      end
      s[4*i +: 4] = x[3:0];
    end
    return {o, s};
  endfunction

  // mode 0: in_valid always high, 1: random, 2: alternating starting high.
  task automatic run_op(input int n, input logic [15:0] init, input int mode);
    int          acc_cnt;
    int          cyc;
    logic        v;
    logic [19:0] r;
    bus.start    = 1'b1;
    bus.len      = n[LEN_W-1:0];
    bus.init_val = init;
    tick();
    bus.start = 1'b0;
    m_acc   = init;
    m_ovf   = '0;
    acc_cnt = 0;
    cyc     = 0;
    while (acc_cnt < n && cyc < 4 * n + 10) begin
      chk("accum_out_valid", 16'(bus.out_valid), 16'h0);
      chk("accum_in_ready", 16'(bus.in_ready), 16'h1);
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = 1'($urandom % 2);
      else v = (cyc % 2 == 0);
      bus.in_valid = v;
      if (v && opq.size() != 0) bus.in_data = opq.pop_front();
      else bus.in_data = 16'($urandom);
      tick();
      if (v) begin
        r     = model_add(m_acc, bus.in_data);
        m_acc = r[15:0];
        m_ovf = m_ovf | r[19:16];
        acc_cnt++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("accept_budget", 16'(acc_cnt), 16'(n));
    chk("done_out_valid", 16'(bus.out_valid), 16'h1);
    chk("done_busy", 16'(bus.busy), 16'h1);
    chk("done_result", bus.result, m_acc);
    chk("done_ovf", 16'(bus.ovf), 16'(m_ovf));
  endtask

  task automatic finish_op(input int stall);
    bus.out_ready = 1'b0;
    repeat (stall) begin
      tick();
      chk("hold_out_valid", 16'(bus.out_valid), 16'h1);
      chk("hold_result", bus.result, m_acc);
      chk("hold_ovf", 16'(bus.ovf), 16'(m_ovf));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("post_out_valid", 16'(bus.out_valid), 16'h0);
    chk("post_busy", 16'(bus.busy), 16'h0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.init_val = '0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_in_ready", 16'(bus.in_ready), 16'h0);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_ovf", 16'(bus.ovf), 16'h0);
    rst = 1'b0;
    tick();

    // Plain addition, no lane overflows.
    opq = '{16'h2222};
    run_op(1, 16'h1234, 0);
    chk("noovf_result", bus.result, 16'h3456);
    chk("noovf_ovf", 16'(bus.ovf), 16'h0);
    finish_op(0);

    // Positive and negative saturation in every lane.
    opq = '{16'h1111};
    run_op(1, 16'h7777, 0);
    chk("possat_result", bus.result, 16'h7777);
    chk("possat_ovf", 16'(bus.ovf), 16'hF);
    finish_op(0);
    opq = '{16'hFFFF};
    run_op(1, 16'h8888, 0);
    chk("negsat_result", bus.result, 16'h8888);
    chk("negsat_ovf", 16'(bus.ovf), 16'hF);
    finish_op(0);

    // Mixed lanes; lane3 flag must survive a later clean operand.
    opq = '{16'h1010, 16'h0000};
    run_op(2, 16'h7080, 0);
    chk("sticky_result", bus.result, 16'h7090);
    chk("sticky_ovf", 16'(bus.ovf), 16'h8);
    finish_op(0);

    // Alternating in_valid, then consumer stalls four cycles in DONE.
    opq = '{16'h1111, 16'h2222, 16'h0333};
    run_op(3, 16'h0000, 2);
    chk("bp_result", bus.result, 16'h3666);
    finish_op(4);

    // Zero-length stream goes straight to DONE.
    run_op(0, 16'hABCD, 0);
    chk("len0_result", bus.result, 16'hABCD);
    chk("len0_ovf", 16'(bus.ovf), 16'h0);
    finish_op(1);

    // start while in ACCUM must be ignored.
    bus.start    = 1'b1;
    bus.len      = 8'd2;
    bus.init_val = 16'h0101;
    tick();
    bus.len      = 8'd0;
    bus.init_val = 16'hFFFF;
    tick();
    bus.start = 1'b0;
    chk("ign_start_busy", 16'(bus.busy), 16'h1);
    chk("ign_start_out_valid", 16'(bus.out_valid), 16'h0);
    chk("ign_start_in_ready", 16'(bus.in_ready), 16'h1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0202;
    tick();
    bus.in_data  = 16'h0303;
    tick();
    bus.in_valid = 1'b0;
    m_acc = 16'h0606;
    m_ovf = 4'h0;
    chk("ign_start_out_valid2", 16'(bus.out_valid), 16'h1);
    chk("ign_start_result", bus.result, 16'h0606);
    finish_op(1);

    // abort mid-stream with an operand offered in the same cycle.
    bus.start    = 1'b1;
    bus.len      = 8'd3;
    bus.init_val = 16'h1000;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0001;
    tick();
    bus.abort = 1'b1;
    #1;
    chk("abort_in_ready", 16'(bus.in_ready), 16'h0);
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_busy", 16'(bus.busy), 16'h0);
    chk("abort_out_valid", 16'(bus.out_valid), 16'h0);
    tick();
    chk("abort_out_valid2", 16'(bus.out_valid), 16'h0);
    opq = '{16'h4321};
    run_op(1, 16'h0000, 0);
    chk("after_abort_result", bus.result, 16'h4321);
    chk("after_abort_ovf", 16'(bus.ovf), 16'h0);
    finish_op(0);

    // start and abort together in IDLE: abort wins.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.len   = 8'd1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", 16'(bus.busy), 16'h0);
    chk("start_abort_in_ready", 16'(bus.in_ready), 16'h0);

    // Asynchronous reset in the middle of ACCUM.
    bus.start    = 1'b1;
    bus.len      = 8'd4;
    bus.init_val = 16'h5555;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1111;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 16'(bus.busy), 16'h0);
    chk("midrst_out_valid", 16'(bus.out_valid), 16'h0);
    chk("midrst_in_ready", 16'(bus.in_ready), 16'h0);
    chk("midrst_result", bus.result, 16'h0000);
    chk("midrst_ovf", 16'(bus.ovf), 16'h0);
    bus.in_valid = 1'b0;
    tick();
    chk("midrst_busy2", 16'(bus.busy), 16'h0);
    rst = 1'b0;
    tick();

    // Longest legal stream.
    run_op(255, 16'($urandom), 0);
    finish_op(0);

    // Random lengths, operands, backpressure and result stalls.
    repeat (40) begin
      run_op(int'($urandom_range(0, 20)), 16'($urandom), int'($urandom_range(0, 1)));
      finish_op(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
